// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count_seq_ctrl sequencer.
// Holds the FSM state encoding and default datapath widths.
package count_seq_pkg;

   localparam int WIDTH_DEF = 12;
   localparam int PRE_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ARM  = 2'b01,
      RUN  = 2'b10,
      HOLD = 2'b11
   } state_e;

endpackage

// File: rtl/count_core.sv
// Counter register with sync clear, load and enable.
// Ports: clk_i, rst_ni, clr_i, load_i, load_val_i, en_i, [dec_i], count_o.
// Macro COUNT_SEQ_CTRL_DOWN_EN adds dec_i (decrement on enable).
module count_core
   import count_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
`ifdef COUNT_SEQ_CTRL_DOWN_EN
   input  logic             dec_i,
`endif
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
`ifdef COUNT_SEQ_CTRL_DOWN_EN
         count_d = dec_i ? count_q - 1'b1 : count_q + 1'b1;
`else
         count_d = count_q + 1'b1;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer for the event counter: arm, prescale, pause, stop, terminal.
// Ports: CLK, RST(async low), START, STOP, PAUSE, PERIODIC, LIMIT,
// PRESCALE, [DIR], COUNT, BUSY, DONE. Macro COUNT_SEQ_CTRL_DOWN_EN
// enables down-counting via DIR.
module count_seq_ctrl
   import count_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int PRE_W = PRE_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             STOP,
   input  logic             PAUSE,
   input  logic             PERIODIC,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic [PRE_W-1:0] PRESCALE,
`ifdef COUNT_SEQ_CTRL_DOWN_EN
   input  logic             DIR,
`endif
   output logic [WIDTH-1:0] COUNT,
   output logic             BUSY,
   output logic             DONE
);

   state_e           state_q, state_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             per_q, per_d;
   logic             done_q, done_d;

   logic             clr, load, en;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] term_val;
   logic             tick, at_term;

`ifdef COUNT_SEQ_CTRL_DOWN_EN
   logic dir_q, dir_d;
   assign term_val = dir_q ? '0 : lim_q;
`else
   assign term_val = lim_q;
`endif

   assign tick    = (presc_q == pre_q);
   assign at_term = (COUNT == term_val);

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      pre_d    = pre_q;
      lim_d    = lim_q;
      per_d    = per_q;
      done_d   = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      en       = 1'b0;
      load_val = lim_q;
`ifdef COUNT_SEQ_CTRL_DOWN_EN
      dir_d    = dir_q;
`endif
      if (STOP) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (START && (LIMIT != '0)) begin
                  lim_d   = LIMIT;
                  pre_d   = PRESCALE;
                  per_d   = PERIODIC;
                  state_d = ARM;
`ifdef COUNT_SEQ_CTRL_DOWN_EN
                  dir_d    = DIR;
                  load_val = LIMIT;
                  load     = DIR;
                  clr      = !DIR;
`else
                  clr      = 1'b1;
`endif
               end
            end
            ARM: begin
               presc_d = '0;
               state_d = RUN;
            end
            RUN, HOLD: begin
               state_d = PAUSE ? HOLD : RUN;
               // A terminal tick in RUN wins over a same-cycle PAUSE.
               if (!PAUSE || (state_q == RUN && tick && at_term)) begin
                  presc_d = tick ? '0 : presc_q + 1'b1;
                  if (tick && at_term) begin
                     done_d = 1'b1;
                     if (!per_q) begin
                        state_d = IDLE;
                     end else begin
`ifdef COUNT_SEQ_CTRL_DOWN_EN
                        load = dir_q;
                        clr  = !dir_q;
`else
                        clr  = 1'b1;
`endif
                     end
                  end else if (tick) begin
                     en = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         presc_q <= '0;
         pre_q   <= '0;
         lim_q   <= '0;
         per_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         pre_q   <= pre_d;
         lim_q   <= lim_d;
         per_q   <= per_d;
         done_q  <= done_d;
      end
   end

`ifdef COUNT_SEQ_CTRL_DOWN_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) dir_q <= 1'b0;
      else      dir_q <= dir_d;
   end
`endif

   count_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk_i      (CLK),
      .rst_ni     (RST),
      .clr_i      (clr),
      .load_i     (load),
      .load_val_i (load_val),
      .en_i       (en),
`ifdef COUNT_SEQ_CTRL_DOWN_EN
      .dec_i      (dir_q),
`endif
      .count_o    (COUNT)
   );

   assign BUSY = (state_q != IDLE);
   assign DONE = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl (up-count build).
// Vectors cover reset, one-shot, periodic, pause, stop and rejection.
module tb_count_seq_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        START = 1'b0;
   logic        STOP = 1'b0;
   logic        PAUSE = 1'b0;
   logic        PERIODIC = 1'b0;
   logic [11:0] LIMIT = '0;
   logic [7:0]  PRESCALE = '0;
`ifdef COUNT_SEQ_CTRL_DOWN_EN
   logic        DIR = 1'b0;
`endif
   logic [11:0] COUNT;
   logic        BUSY;
   logic        DONE;

   int nerr = 0;
   int nchk = 0;

   count_seq_ctrl #(
      .WIDTH(12),
      .PRE_W(8)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .STOP     (STOP),
      .PAUSE    (PAUSE),
      .PERIODIC (PERIODIC),
      .LIMIT    (LIMIT),
      .PRESCALE (PRESCALE),
`ifdef COUNT_SEQ_CTRL_DOWN_EN
      .DIR      (DIR),
`endif
      .COUNT    (COUNT),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int got, input int exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Drives START across one edge: that edge is "edge 0".
   task automatic kick(input int lim, input int pre, input bit per);
      LIMIT    = 12'(lim);
      PRESCALE = 8'(pre);
      PERIODIC = per;
      START    = 1'b1;
      cyc();
      START    = 1'b0;
   endtask

   int ec;
   int pause_cnt [1:10] = '{0, 1, 1, 1, 1, 1, 2, 3, 3, 3};

   initial begin
      #2;
      chk("rst_count", COUNT, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      #1 RST = 1'b1;
      cyc();
      chk("idle_busy", BUSY, 0);

      // One-shot LIMIT=3, PRESCALE=0
      kick(3, 0, 0);
      chk("os_arm_busy", BUSY, 1);
      chk("os_arm_count", COUNT, 0);
      for (int k = 1; k <= 6; k++) begin
         cyc();
         ec = (k < 2) ? 0 : ((k - 1 > 3) ? 3 : k - 1);
         chk($sformatf("os_count_e%0d", k), COUNT, ec);
         chk($sformatf("os_done_e%0d", k), DONE, (k == 5) ? 1 : 0);
         chk($sformatf("os_busy_e%0d", k), BUSY, (k <= 4) ? 1 : 0);
      end

      // START during RUN and LIMIT/PRESCALE change mid-run are ignored
      kick(3, 0, 0);
      cyc();
      START    = 1'b1;
      LIMIT    = 12'd1;
      PRESCALE = 8'd5;
      cyc();
      chk("rej_count_e2", COUNT, 1);
      START = 1'b0;
      for (int k = 3; k <= 6; k++) begin
         cyc();
         ec = (k - 1 > 3) ? 3 : k - 1;
         chk($sformatf("rej_count_e%0d", k), COUNT, ec);
         chk($sformatf("rej_done_e%0d", k), DONE, (k == 5) ? 1 : 0);
      end

      // START with LIMIT=0 is ignored
      LIMIT = 12'd0;
      START = 1'b1;
      cyc();
      START = 1'b0;
      chk("zero_busy0", BUSY, 0);
      cyc();
      chk("zero_busy1", BUSY, 0);

      // START together with STOP in IDLE
      LIMIT = 12'd3;
      START = 1'b1;
      STOP  = 1'b1;
      cyc();
      START = 1'b0;
      STOP  = 1'b0;
      chk("ss_busy", BUSY, 0);
      chk("ss_count", COUNT, 3);

      // Periodic LIMIT=2, PRESCALE=1: DONE every 6 cycles
      kick(2, 1, 1);
      for (int k = 1; k <= 20; k++) begin
         cyc();
         ec = ((k - 1) / 2) % 3;
         chk($sformatf("per_count_e%0d", k), COUNT, ec);
         chk($sformatf("per_done_e%0d", k), DONE,
             (k > 1 && (k - 1) % 6 == 0) ? 1 : 0);
         chk($sformatf("per_busy_e%0d", k), BUSY, 1);
      end
      STOP = 1'b1;
      cyc();
      STOP = 1'b0;
      chk("per_stop_busy", BUSY, 0);
      chk("per_stop_done", DONE, 0);
      chk("per_stop_count", COUNT, 0);

      // Pause for 4 edges (3..6): DONE moves from edge 5 to edge 9
      kick(3, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         PAUSE = (k >= 3 && k <= 6);
         cyc();
         chk($sformatf("pz_count_e%0d", k), COUNT, pause_cnt[k]);
         chk($sformatf("pz_done_e%0d", k), DONE, (k == 9) ? 1 : 0);
         chk($sformatf("pz_busy_e%0d", k), BUSY, (k <= 8) ? 1 : 0);
      end
      PAUSE = 1'b0;

      // STOP on the terminal-tick cycle
      kick(3, 0, 0);
      for (int k = 1; k <= 4; k++) cyc();
      chk("sc_pre_count", COUNT, 3);
      STOP = 1'b1;
      cyc();
      STOP = 1'b0;
      chk("sc_busy", BUSY, 0);
      chk("sc_done", DONE, 0);
      chk("sc_count", COUNT, 3);
      cyc();
      chk("sc_done2", DONE, 0);
      chk("sc_count2", COUNT, 3);

      // Asynchronous reset mid-run at COUNT=5
      kick(10, 0, 0);
      for (int k = 1; k <= 6; k++) cyc();
      chk("ar_pre_count", COUNT, 5);
      RST = 1'b0;
      #1;
      chk("ar_count", COUNT, 0);
      chk("ar_busy", BUSY, 0);
      chk("ar_done", DONE, 0);
      #2 RST = 1'b1;
      cyc();
      chk("ar_idle_busy", BUSY, 0);
      chk("ar_idle_count", COUNT, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=1 exp=0");
      $fatal(1);
   end

endmodule
